mem_port_arbiter: RTL and testbench

//  Shares the single-ported, word-indexed data memory between instruction fetch (IF) and the

---
 rtl/mem_port_arbiter_pkg.sv | 47 ++++
 rtl/mem_port_arbiter_load_extend.sv | 22 ++
 rtl/mem_port_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: FSM states, grant owner, RV32 load/store funct3 codes.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    G_IF = 1'b0,
    G_D  = 1'b1
  } owner_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Unknown funct3 codes are rejected the same way as misaligned addresses.
  function automatic logic is_misaligned(input logic we, input logic [2:0] f3,
                                         input logic [1:0] a);
    logic bad;
    bad = 1'b1;
    if (we) begin
      case (f3)
        F3_SB:   bad = 1'b0;
        F3_SH:   bad = a[0];
        F3_SW:   bad = |a;
        default: bad = 1'b1;
      endcase
    end else begin
      case (f3)
        F3_LB, F3_LBU: bad = 1'b0;
        F3_LH, F3_LHU: bad = a[0];
        F3_LW:         bad = |a;
        default:       bad = 1'b1;
      endcase
    end
    return bad;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_load_extend.sv
// Combinational load extension: picks the low byte/half of the memory word and sign/zero extends it.
module load_extend
  import mem_port_arbiter_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] word,
  output logic [31:0] data
);

  always_comb begin
    data = word;
    case (funct3)
      F3_LB:   data = {{24{word[7]}}, word[7:0]};
      F3_LH:   data = {{16{word[15]}}, word[15:0]};
      F3_LW:   data = word;
      F3_LBU:  data = {24'b0, word[7:0]};
      F3_LHU:  data = {16'b0, word[15:0]};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates IF and D onto one memory port; req->ready latency 2 cycles, one access per 3 cycles.
// Requesters stall by holding req until their 1-cycle ready pulse; D has priority, IF forced after MAX_DSTREAK.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MEM_AW      = 6,
  parameter int MAX_DSTREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_ready,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [2:0]        d_funct3,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ready,
  output logic [31:0]       d_rdata,
  output logic              d_misalign,
  output logic [MEM_AW-1:0] m_addr,
  output logic              m_read,
  output logic              m_write,
  output logic [2:0]        m_funct3,
  output logic [31:0]       m_wdata,
  input  logic [31:0]       m_rdata
);

  localparam int SKW = $clog2(MAX_DSTREAK + 1);
  localparam logic [SKW-1:0] STREAK_MAX = SKW'(MAX_DSTREAK);

  state_t         state;
  owner_t         owner;
  logic [SKW-1:0] streak;
  logic [2:0]     ld_f3;
  logic           reject;
  logic           grant_d;
  logic           grant_if;
  logic           d_bad;
  logic [31:0]    ext_data;
  logic           unused_addr;

  assign grant_d     = d_req && !(if_req && (streak == STREAK_MAX));
  assign grant_if    = if_req && !grant_d;
  assign d_bad       = is_misaligned(d_we, d_funct3, d_addr[1:0]);
  assign unused_addr = ^{d_addr[31:MEM_AW+2], if_addr[31:MEM_AW+2], if_addr[1:0]};

  load_extend u_load_extend (
    .funct3 (ld_f3),
    .word   (m_rdata),
    .data   (ext_data)
  );

  // Rejected D accesses still pass through ACCESS (with no strobes) so every request sees the same latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      owner      <= G_IF;
      streak     <= '0;
      ld_f3      <= '0;
      reject     <= 1'b0;
      if_ready   <= 1'b0;
      if_rdata   <= '0;
      d_ready    <= 1'b0;
      d_rdata    <= '0;
      d_misalign <= 1'b0;
      m_addr     <= '0;
      m_read     <= 1'b0;
      m_write    <= 1'b0;
      m_funct3   <= '0;
      m_wdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            owner  <= G_D;
            ld_f3  <= d_funct3;
            reject <= d_bad;
            state  <= ACCESS;
            if (!d_bad) begin
              m_addr   <= d_addr[MEM_AW+1:2];
              m_funct3 <= d_funct3;
              m_wdata  <= d_wdata;
              m_read   <= !d_we;
              m_write  <= d_we;
            end
            if (!if_req) streak <= '0;
            else if (streak != STREAK_MAX) streak <= streak + 1'b1;
          end else if (grant_if) begin
            owner  <= G_IF;
            reject <= 1'b0;
            state  <= ACCESS;
            m_addr <= if_addr[MEM_AW+1:2];
            m_read <= 1'b1;
            streak <= '0;
          end else begin
            streak <= '0;
          end
        end
        ACCESS: begin
          m_read  <= 1'b0;
          m_write <= 1'b0;
          state   <= RESP;
          if (owner == G_IF) begin
            if_rdata <= m_rdata;
            if_ready <= 1'b1;
          end else begin
            d_ready    <= 1'b1;
            d_misalign <= reject;
            if (reject) d_rdata <= '0;
            else if (m_read) d_rdata <= ext_data;
          end
        end
        RESP: begin
          if_ready   <= 1'b0;
          d_ready    <= 1'b0;
          d_misalign <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed requests push expected responses, a monitor pops on ready.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    logic        chk;
  } dexp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [2:0]  d_funct3;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        d_misalign;
  logic [5:0]  m_addr;
  logic        m_read;
  logic        m_write;
  logic [2:0]  m_funct3;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;

  logic [31:0] mem [0:63];
  logic        load_mem;

  dexp_t       exp_d[$];
  logic [31:0] exp_if[$];
  logic        exp_order[$];
  int          errors = 0;
  int          checks = 0;
  int          resp_cnt = 0;
  int          strobe_cnt = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_AW(6), .MAX_DSTREAK(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata), .d_misalign(d_misalign),
    .m_addr(m_addr), .m_read(m_read), .m_write(m_write), .m_funct3(m_funct3),
    .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  // Memory: combinational read, posedge write into the low lanes selected by m_funct3.
  assign m_rdata = m_read ? mem[m_addr] : 32'h0;

  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[2] <= 32'h0BADF00D;
      mem[3] <= 32'h0000F08C;
      mem[4] <= 32'h00A00093;
    end else if (m_write) begin
      case (m_funct3)
        3'b000:  mem[m_addr][7:0]  <= m_wdata[7:0];
        3'b001:  mem[m_addr][15:0] <= m_wdata[15:0];
        default: mem[m_addr]       <= m_wdata;
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic monitor_loop();
    dexp_t       e;
    logic [31:0] w;
    logic        o;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (m_read || m_write) strobe_cnt++;
        if (d_ready || if_ready) begin
          resp_cnt++;
          check("ready_onehot", {31'b0, d_ready & if_ready}, 32'h0);
          if (exp_order.size() > 0) begin
            o = exp_order.pop_front();
            check("grant_order_is_d", {31'b0, d_ready}, {31'b0, o});
          end
        end
        if (d_ready) begin
          if (exp_d.size() == 0) begin
            checks++; errors++;
            $display("FAIL d_unexpected: d_ready=1 with no pending D request");
          end else begin
            e = exp_d.pop_front();
            check("d_misalign", {31'b0, d_misalign}, {31'b0, e.mis});
            if (e.chk) check("d_rdata", d_rdata, e.rdata);
          end
        end
        if (if_ready) begin
          if (exp_if.size() == 0) begin
            checks++; errors++;
            $display("FAIL if_unexpected: if_ready=1 with no pending fetch");
          end else begin
            w = exp_if.pop_front();
            check("if_rdata", if_rdata, w);
          end
        end
      end
    end
  endtask

  // Entered and left at a negedge with the DUT idle.
  task automatic d_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata,
                          input logic exp_mis, input logic chk, input logic [1:0] strobe);
    int   cyc;
    logic got;
    exp_d.push_back('{exp_rdata, exp_mis, chk});
    d_we = we; d_funct3 = f3; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
    cyc = 0; got = 1'b0;
    while (!got && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) begin
        check("d_strobes", {30'b0, m_read, m_write}, {30'b0, strobe});
        if (strobe != 2'b00) check("d_m_addr", {26'b0, m_addr}, {26'b0, addr[7:2]});
      end
      if (d_ready) got = 1'b1;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL d_timeout: no d_ready after %0d cycles, expected within 10", cyc);
    end else begin
      check("d_latency", cyc, 32'd2);
    end
    d_req = 1'b0;
    @(negedge clk); @(posedge clk); @(negedge clk);
  endtask

  task automatic if_fetch(input logic [31:0] addr, input logic [31:0] exp_w);
    int   cyc;
    logic got;
    exp_if.push_back(exp_w);
    if_addr = addr; if_req = 1'b1;
    cyc = 0; got = 1'b0;
    while (!got && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) begin
        check("if_m_read", {31'b0, m_read}, 32'h1);
        check("if_m_addr", {26'b0, m_addr}, {26'b0, addr[7:2]});
      end
      if (if_ready) got = 1'b1;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL if_timeout: no if_ready after %0d cycles, expected within 10", cyc);
    end else begin
      check("if_latency", cyc, 32'd2);
    end
    if_req = 1'b0;
    @(negedge clk); @(posedge clk); @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   start;
    int   snap;
    logic got;
    rst = 1'b0; load_mem = 1'b1;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_funct3 = '0; d_addr = '0; d_wdata = '0;
    fork
      monitor_loop();
    join_none
    repeat (2) @(posedge clk);
    @(negedge clk);
    load_mem = 1'b0;
    check("reset_flags", {27'b0, if_ready, d_ready, d_misalign, m_read, m_write}, 32'h0);
    check("reset_m_addr_f3", {23'b0, m_addr, m_funct3}, 32'h0);
    check("reset_m_wdata", m_wdata, 32'h0);
    check("reset_rdata", if_rdata | d_rdata, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // Reset while a store is in ACCESS: write strobe must vanish before the next edge.
    d_we = 1'b1; d_funct3 = F3_SW; d_addr = 32'h8; d_wdata = 32'hDEADBEEF; d_req = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 5 && !got; i++) begin
      @(posedge clk); #1;
      if (m_write) got = 1'b1;
    end
    check("rst_store_reached_access", {31'b0, got}, 32'h1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_drops_m_write", {31'b0, m_write}, 32'h0);
    d_req = 1'b0;
    @(posedge clk); @(negedge clk);
    check("rst_mem2_untouched", mem[2], 32'h0BADF00D);
    rst = 1'b1;
    @(negedge clk);

    if_fetch(32'h10, 32'h00A00093);

    d_access(1'b0, F3_LB,  32'hC, 32'h0, 32'hFFFFFF8C, 1'b0, 1'b1, 2'b10);
    d_access(1'b0, F3_LBU, 32'hC, 32'h0, 32'h0000008C, 1'b0, 1'b1, 2'b10);
    d_access(1'b0, F3_LH,  32'hC, 32'h0, 32'hFFFFF08C, 1'b0, 1'b1, 2'b10);
    d_access(1'b0, F3_LHU, 32'hC, 32'h0, 32'h0000F08C, 1'b0, 1'b1, 2'b10);
    d_access(1'b0, F3_LW,  32'hC, 32'h0, 32'h0000F08C, 1'b0, 1'b1, 2'b10);

    d_access(1'b1, F3_SW, 32'h4, 32'h11223344, 32'h0, 1'b0, 1'b0, 2'b01);
    check("mem1_after_sw", mem[1], 32'h11223344);
    d_access(1'b1, F3_SB, 32'h4, 32'hFFFFFFAB, 32'h0, 1'b0, 1'b0, 2'b01);
    check("mem1_after_sb", mem[1], 32'h112233AB);
    d_access(1'b1, F3_SH, 32'h4, 32'h5555BEEF, 32'h0, 1'b0, 1'b0, 2'b01);
    check("mem1_after_sh", mem[1], 32'h1122BEEF);
    d_access(1'b0, F3_LW, 32'h4, 32'h0, 32'h1122BEEF, 1'b0, 1'b1, 2'b10);

    // Rejected accesses: no strobes, d_rdata cleared, memory intact.
    snap = strobe_cnt;
    d_access(1'b0, F3_LW,  32'h6, 32'h0,        32'h0, 1'b1, 1'b1, 2'b00);
    d_access(1'b1, F3_SH,  32'h5, 32'hCAFEF00D, 32'h0, 1'b1, 1'b1, 2'b00);
    d_access(1'b1, 3'b011, 32'h8, 32'hCAFEF00D, 32'h0, 1'b1, 1'b1, 2'b00);
    d_access(1'b0, 3'b110, 32'h8, 32'h0,        32'h0, 1'b1, 1'b1, 2'b00);
    check("misalign_no_strobes", strobe_cnt - snap, 32'h0);
    check("misalign_mem2_kept", mem[2], 32'h0BADF00D);
    check("misalign_mem1_kept", mem[1], 32'h1122BEEF);

    // Contention: both held -> D D D D IF, twice.
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) begin
        exp_order.push_back(1'b1);
        exp_d.push_back('{32'h00A00093, 1'b0, 1'b1});
      end
      exp_order.push_back(1'b0);
      exp_if.push_back(32'h0000F08C);
    end
    start = resp_cnt;
    d_we = 1'b0; d_funct3 = F3_LW; d_addr = 32'h10; d_req = 1'b1;
    if_addr = 32'hC; if_req = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk); #1;
      if (resp_cnt - start >= 10) got = 1'b1;
    end
    d_req = 1'b0; if_req = 1'b0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL contention_timeout: %0d responses seen, expected 10", resp_cnt - start);
    end
    repeat (4) @(negedge clk);

    check("order_queue_drained", exp_order.size(), 32'h0);
    check("d_queue_drained", exp_d.size(), 32'h0);
    check("if_queue_drained", exp_if.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
